// File: rtl/tff_counter_ctrl.sv
// Run-control sequencer for a WIDTH-bit T flip-flop bank counting modulo MOD.
// Exposes the per-bit toggle enables so external T-FFs can track the bank.
`timescale 1ns/1ps
module tff_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic             STOP,
    input  logic             UP,
    input  logic             ONESHOT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] T_EN,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MOD);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] load_val;
    logic             load_en;
    logic             counting;
    logic             at_term;

    assign counting = (state == S_RUN) && !STOP;
    assign at_term  = UP ? (q_r == MAXV) : (q_r == '0);

    always_comb begin
        cnt_nxt = q_r;
        if (UP)
            cnt_nxt = (q_r == MAXV) ? '0 : q_r + 1'b1;
        else
            cnt_nxt = (q_r == '0) ? MAXV : q_r - 1'b1;
    end

    // Out-of-range presets clamp to the top of the count range.
    assign load_val = ({1'b0, DIN} >= MODW) ? MAXV : DIN;

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (STOP) begin
                    state_nxt = state;
                end else if (LOAD) begin
                    state_nxt = S_IDLE;
                    load_en   = 1'b1;
                end else if (START) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (STOP)
                    state_nxt = S_IDLE;
                else if (at_term && ONESHOT)
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_IDLE;
            q_r   <= '0;
        end else begin
            state <= state_nxt;
            if (load_en)
                q_r <= load_val;
            else
                q_r <= q_r ^ T_EN;
        end
    end

    assign T_EN = counting ? (q_r ^ cnt_nxt) : '0;
    assign TC   = counting && at_term;
    assign Q    = q_r;
    assign BUSY = (state == S_RUN);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Scoreboard bench for tff_counter_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_tff_counter_ctrl;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       UP = 1'b1;
    logic       ONESHOT = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] DIN = 4'd0;
    logic [3:0] T_EN;
    logic [3:0] Q;
    logic       TC;
    logic       BUSY;
    logic       DONE;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic [3:0] ten;
        logic       tc;
    } obs_t;

    typedef struct {
        int   idx;
        obs_t v;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_step = 0;

    tff_counter_ctrl #(.WIDTH(4), .MOD(10)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP),
        .UP(UP), .ONESHOT(ONESHOT), .LOAD(LOAD), .DIN(DIN),
        .T_EN(T_EN), .Q(Q), .TC(TC), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Inputs for one cycle plus the outputs expected during that cycle.
    task automatic step(
        input logic clr, input logic start, input logic stop,
        input logic up, input logic os, input logic load,
        input logic [3:0] din,
        input logic [3:0] eq, input logic eb, input logic ed,
        input logic [3:0] et, input logic etc
    );
        exp_t e;
        @(posedge CLK);
        #1;
        CLR = clr; START = start; STOP = stop;
        UP = up; ONESHOT = os; LOAD = load; DIN = din;
        n_step++;
        e.idx = n_step;
        e.v = '{q: eq, busy: eb, done: ed, ten: et, tc: etc};
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        obs_t a;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{q: Q, busy: BUSY, done: DONE, ten: T_EN, tc: TC};
                n_chk++;
                if (a !== e.v) begin
                    n_fail++;
                    $display("FAIL step%0d: got Q=%0d BUSY=%b DONE=%b T_EN=%b TC=%b, want Q=%0d BUSY=%b DONE=%b T_EN=%b TC=%b",
                        e.idx, a.q, a.busy, a.done, a.ten, a.tc,
                        e.v.q, e.v.busy, e.v.done, e.v.ten, e.v.tc);
                end
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        //    clr st sp up os ld din    q  b  d  ten     tc
        step(1, 0, 0, 1, 0, 0, 4'd0,  0, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  0, 0, 0, 4'b0000, 0);
        step(0, 1, 0, 1, 0, 0, 4'd0,  0, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  0, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  1, 1, 0, 4'b0011, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  2, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  3, 1, 0, 4'b0111, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  4, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  5, 1, 0, 4'b0011, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  6, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  7, 1, 0, 4'b1111, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  8, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  9, 1, 0, 4'b1001, 1);
        // STOP beats START in RUN
        step(0, 1, 1, 1, 0, 0, 4'd0,  0, 1, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 1, 4'd3,  0, 0, 0, 4'b0000, 0);
        step(0, 1, 0, 0, 0, 0, 4'd0,  3, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  3, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  2, 1, 0, 4'b0011, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  1, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  0, 1, 0, 4'b1001, 1);
        step(0, 0, 0, 1, 0, 0, 4'd0,  9, 1, 0, 4'b1001, 1);
        // LOAD ignored in RUN
        step(0, 0, 0, 1, 0, 1, 4'd5,  0, 1, 0, 4'b0001, 0);
        step(0, 0, 1, 1, 0, 0, 4'd0,  1, 1, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 1, 4'd14, 1, 0, 0, 4'b0000, 0);
        step(0, 1, 0, 1, 0, 1, 4'd7,  9, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  7, 0, 0, 4'b0000, 0);
        // one-shot from 7
        step(0, 1, 0, 1, 1, 0, 4'd0,  7, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 1, 0, 4'd0,  7, 1, 0, 4'b1111, 0);
        step(0, 0, 0, 1, 1, 0, 4'd0,  8, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 1, 0, 4'd0,  9, 1, 0, 4'b1001, 1);
        step(0, 0, 0, 1, 1, 0, 4'd0,  0, 0, 1, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  0, 0, 1, 4'b0000, 0);
        step(0, 1, 0, 1, 0, 0, 4'd0,  0, 0, 1, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  0, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  1, 1, 0, 4'b0011, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  2, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  3, 1, 0, 4'b0111, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  4, 1, 0, 4'b0001, 0);
        // reset mid-run with START held
        step(1, 1, 0, 1, 0, 0, 4'd0,  5, 1, 0, 4'b0011, 0);
        step(0, 1, 0, 1, 0, 0, 4'd0,  0, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  0, 1, 0, 4'b0001, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  1, 1, 0, 4'b0011, 0);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge CLK);
            wait_cyc++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

endmodule
